// File: rtl/bus_addr_ctrl.sv
// -----------------------------------------------------------------------------
// bus_addr_ctrl
//
// Registered bus address decoder and transfer controller. It sits between the
// arbiter grant path and the slave memories/peripherals. A request accepted in
// IDLE is decoded into a one-hot slave select over N_SLV equal, contiguous
// windows of 2**SPAN_W bytes. The transfer is then tracked until the selected
// slave acknowledges it or the ack timeout expires. Unmapped addresses
// complete immediately with an error.
//
// Handshake contract (single place it is written down):
//   - m_req/m_addr are sampled only on a rising edge while the FSM is in IDLE.
//     Requests seen while busy are dropped and never queued.
//   - s_ack is sampled only in ACCESS, and only the bit of the selected slave
//     counts. The other bits, and all of s_ack in IDLE/RESP, are ignored.
//   - Every accepted request yields exactly one RESP cycle. In that cycle
//     either m_ack or m_err is high, never both, and busy is still high.
//
// Parameters
//   ADDR_W   master address width
//   N_SLV    number of slave windows (1..16)
//   SPAN_W   log2 of window size; window i = [i<<SPAN_W, (i+1)<<SPAN_W)
//   TIMEOUT  max ACCESS cycles waiting for ack; 0 disables the timeout
//
// Ports
//   clk        in   1        clock, rising edge
//   reset      in   1        synchronous, active-high reset
//   m_req      in   1        master request (sampled in IDLE only)
//   m_addr     in   ADDR_W   master address, sampled with m_req
//   s_ack      in   N_SLV    per-slave acknowledge
//   s_sel      out  N_SLV    one-hot slave select, registered, 0 outside ACCESS
//   s_offset   out  SPAN_W   latched window-local offset, valid in ACCESS
//   m_ack      out  1        one-cycle pulse: transfer completed
//   m_err      out  1        one-cycle pulse: unmapped address or timeout
//   busy       out  1        high in ACCESS and RESP
//   dbg_state  out  2        current FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module bus_addr_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int N_SLV   = 4,
    parameter int SPAN_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_req,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [N_SLV-1:0]  s_ack,
    output logic [N_SLV-1:0]  s_sel,
    output logic [SPAN_W-1:0] s_offset,
    output logic              m_ack,
    output logic              m_err,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Width of the window index field above the offset bits.
    localparam int IDX_W = ADDR_W - SPAN_W;

    // The counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT+1) bits are
    // always enough. It keeps at least one bit so the disabled case still
    // elaborates.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Counter value that, without an ack, ends the ACCESS phase.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Decode of the incoming address. This only matters in IDLE, where the
    // request is sampled.
    logic [IDX_W-1:0]   idx;
    logic               mapped;
    logic [N_SLV-1:0]   dec_sel;
    logic               sel_ack;
    logic               timed_out;

    always_comb begin
        idx     = m_addr[ADDR_W-1:SPAN_W];
        // Compare at 32 bits so the index field may be narrower or wider
        // than what N_SLV needs.
        mapped  = (32'(idx) < 32'(N_SLV));
        dec_sel = '0;
        for (int i = 0; i < N_SLV; i++) begin
            dec_sel[i] = (32'(idx) == 32'(i));
        end
    end

    // s_sel is one-hot in ACCESS, so masking s_ack with it picks out the
    // selected slave's ack and ignores every other bit.
    assign sel_ack   = |(s_ack & s_sel);
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

    assign dbg_state = state;

    // Single registered FSM. Every output is a flop updated here, so the
    // outputs change only on the rising clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            s_sel    <= '0;
            s_offset <= '0;
            m_ack    <= 1'b0;
            m_err    <= 1'b0;
            busy     <= 1'b0;
            cnt      <= '0;
        end else begin
            // Response flags are pulses. They default low and are set only
            // on the edge that enters RESP.
            m_ack <= 1'b0;
            m_err <= 1'b0;

            case (state)
                IDLE: begin
                    s_sel    <= '0;
                    s_offset <= '0;
                    busy     <= 1'b0;
                    cnt      <= '0;
                    if (m_req) begin
                        busy <= 1'b1;
                        if (mapped) begin
                            state    <= ACCESS;
                            s_sel    <= dec_sel;
                            s_offset <= m_addr[SPAN_W-1:0];
                        end else begin
                            // No slave owns this address. Report the error
                            // straight away and never drive a select.
                            state <= RESP;
                            m_err <= 1'b1;
                        end
                    end
                end

                ACCESS: begin
                    if (sel_ack) begin
                        // The ack takes priority over a timeout in the same
                        // cycle.
                        state    <= RESP;
                        s_sel    <= '0;
                        s_offset <= '0;
                        m_ack    <= 1'b1;
                    end else if (timed_out) begin
                        state    <= RESP;
                        s_sel    <= '0;
                        s_offset <= '0;
                        m_err    <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        // This is bounded by the timeout check above, so it
                        // never wraps. With the timeout disabled the counter
                        // just holds at 0.
                        cnt <= cnt + 1'b1;
                    end
                end

                RESP: begin
                    // RESP always lasts one cycle. A request seen here is
                    // dropped.
                    state    <= IDLE;
                    s_sel    <= '0;
                    s_offset <= '0;
                    busy     <= 1'b0;
                    cnt      <= '0;
                end

                default: begin
                    state    <= IDLE;
                    s_sel    <= '0;
                    s_offset <= '0;
                    busy     <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

    // Structural invariants of the select and response outputs.
    a_sel_onehot0 : assert property (@(posedge clk) disable iff (reset)
        $onehot0(s_sel));
    a_resp_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(m_ack && m_err));
    a_sel_implies_busy : assert property (@(posedge clk) disable iff (reset)
        (s_sel != '0) |-> busy);

endmodule

// File: tb/tb_bus_addr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_addr_ctrl
//
// Bench for bus_addr_ctrl. The driver issues directed and then random
// transfers. For each accepted request it pushes the expected response,
// computed from the address-map and timeout rules, into exp_q. A separate
// monitor watches the DUT. Whenever a response pulse appears it pops exp_q and
// compares the result kind, the select and offset seen during ACCESS, the
// ACCESS length and the total busy length.
// -----------------------------------------------------------------------------
module tb_bus_addr_ctrl;

    localparam int ADDR_W  = 8;
    localparam int N_SLV   = 4;
    localparam int SPAN_W  = 5;
    localparam int TIMEOUT = 15;
    localparam int NO_ACK  = 1000;   // ack delay that never happens
    localparam int EW      = 18;     // {is_err, sel[3:0], off[4:0], len[7:0]}

    logic              clk;
    logic              reset;
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic [N_SLV-1:0]  s_ack;
    logic [N_SLV-1:0]  s_sel;
    logic [SPAN_W-1:0] s_offset;
    logic              m_ack;
    logic              m_err;
    logic              busy;
    logic [1:0]        dbg_state;

    logic [EW-1:0] exp_q[$];
    int checks    = 0;
    int failures  = 0;
    int issued    = 0;
    int responses = 0;

    bus_addr_ctrl #(
        .ADDR_W (ADDR_W),
        .N_SLV  (N_SLV),
        .SPAN_W (SPAN_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .s_ack    (s_ack),
        .s_sel    (s_sel),
        .s_offset (s_offset),
        .m_ack    (m_ack),
        .m_err    (m_err),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        checks++;
        failures++;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one transfer. The expected response comes from the address map:
    // unmapped -> error with no ACCESS; mapped -> ACCESS lasts until the ack
    // cycle, capped at TIMEOUT cycles. An ack in the last allowed cycle still
    // counts as success.
    task automatic run_txn(input logic [7:0] addr, input int delay, input bit fixed,
                           input logic [3:0] fnoise, input bit hold);
        int         idx;
        bit         mapped;
        int         len;
        bit         is_err;
        logic [3:0] selbit;
        logic [4:0] off;
        logic [3:0] nz;
        idx    = int'(addr) / 32;
        mapped = (idx < N_SLV);
        selbit = mapped ? 4'(1 << idx) : 4'b0000;
        off    = mapped ? addr[4:0] : 5'd0;
        if (!mapped) begin
            len = 0; is_err = 1'b1;
        end else if (delay < TIMEOUT) begin
            len = delay + 1; is_err = 1'b0;
        end else begin
            len = TIMEOUT; is_err = 1'b1;
        end

        @(negedge clk);
        m_req  = 1'b1;
        m_addr = addr;
        s_ack  = fixed ? fnoise : 4'($urandom);
        @(posedge clk);                       // accept edge
        exp_q.push_back({is_err, selbit, off, 8'(len)});
        issued++;

        for (int k = 0; k < len; k++) begin   // ACCESS cycles
            @(negedge clk);
            m_req  = hold ? 1'b1 : 1'($urandom_range(0, 1));
            m_addr = 8'($urandom);
            nz     = fixed ? fnoise : 4'($urandom);
            s_ack  = (k == delay) ? (nz | selbit) : (nz & ~selbit);
        end

        @(negedge clk);                       // RESP cycle
        m_req  = hold ? 1'b1 : 1'($urandom_range(0, 1));
        m_addr = hold ? 8'h60 : 8'($urandom);
        s_ack  = fixed ? fnoise : 4'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m_req  = 1'b0;
            m_addr = 8'($urandom);
            s_ack  = 4'($urandom);
        end
    endtask

    // Reset asserted in the second ACCESS cycle must abort the transfer
    // silently.
    task automatic reset_mid_access();
        @(negedge clk);
        m_req  = 1'b1;
        m_addr = 8'h45;
        s_ack  = 4'b0000;
        @(posedge clk);
        exp_q.push_back({1'b0, 4'b0100, 5'h05, 8'd1});
        issued++;
        @(negedge clk);                       // ACCESS cycle 1
        m_req = 1'b0;
        s_ack = 4'b1011;
        @(negedge clk);                       // ACCESS cycle 2
        reset = 1'b1;
        s_ack = 4'b0000;
        @(posedge clk);
        exp_q.delete();
        issued--;
        @(negedge clk);
        chk("rst_mid_sel", 32'(s_sel), 32'(0));
        chk("rst_mid_offset", 32'(s_offset), 32'(0));
        chk("rst_mid_ack", 32'(m_ack), 32'(0));
        chk("rst_mid_err", 32'(m_err), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_state_idle", 32'(dbg_state), 32'(0));   // IDLE encodes as 0
        reset = 1'b0;
        idle_cycles(3);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [3:0]    rec_sel;
        logic [4:0]    rec_off;
        int            acc_len;
        int            busy_len;
        bit            stable;
        logic [EW-1:0] e;
        rec_sel = '0; rec_off = '0; acc_len = 0; busy_len = 0; stable = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                rec_sel = '0; rec_off = '0; acc_len = 0; busy_len = 0; stable = 1'b1;
            end else begin
                chk("sel_onehot0", 32'($onehot0(s_sel)), 32'(1));
                if (s_sel != 4'b0000) begin
                    if (acc_len == 0) begin
                        rec_sel = s_sel;
                        rec_off = s_offset;
                    end else if (s_sel != rec_sel || s_offset != rec_off) begin
                        stable = 1'b0;
                    end
                    acc_len++;
                end
                if (busy) busy_len++;

                if (m_ack || m_err) begin
                    chk("resp_exclusive", 32'(m_ack && m_err), 32'(0));
                    chk("resp_sel_zero", 32'(s_sel), 32'(0));
                    chk("resp_busy", 32'(busy), 32'(1));
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_resp actual=ack%0d/err%0d required=none at %0t",
                                 m_ack, m_err, $time);
                    end else begin
                        e = exp_q.pop_front();
                        responses++;
                        chk("resp_is_err", 32'(m_err), 32'(e[17]));
                        chk("resp_is_ack", 32'(m_ack), 32'(!e[17]));
                        chk("access_sel", 32'(rec_sel), 32'(e[16:13]));
                        chk("access_offset", 32'(rec_off), 32'(e[12:8]));
                        chk("access_len", 32'(acc_len), 32'(e[7:0]));
                        chk("busy_len", 32'(busy_len), 32'(e[7:0]) + 32'd1);
                        chk("sel_stable", 32'(stable), 32'(1));
                    end
                    rec_sel = '0; rec_off = '0; acc_len = 0; busy_len = 0; stable = 1'b1;
                end else if (!busy) begin
                    chk("idle_sel", 32'(s_sel), 32'(0));
                    chk("idle_offset", 32'(s_offset), 32'(0));
                    rec_sel = '0; rec_off = '0; acc_len = 0; busy_len = 0; stable = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int d;
        int sel_d;
        reset  = 1'b1;
        m_req  = 1'b0;
        m_addr = '0;
        s_ack  = '0;
        repeat (3) @(negedge clk);
        chk("reset_sel", 32'(s_sel), 32'(0));
        chk("reset_offset", 32'(s_offset), 32'(0));
        chk("reset_ack", 32'(m_ack), 32'(0));
        chk("reset_err", 32'(m_err), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        idle_cycles(2);

        // Directed transfers.
        run_txn(8'h25, 3, 1'b0, 4'b0000, 1'b0);       // ack 3 cycles into ACCESS
        idle_cycles(1);
        run_txn(8'h90, 0, 1'b0, 4'b0000, 1'b0);       // unmapped
        idle_cycles(1);
        run_txn(8'h7F, NO_ACK, 1'b0, 4'b0000, 1'b0);  // timeout
        idle_cycles(1);
        run_txn(8'h00, 5, 1'b1, 4'b1110, 1'b0);       // other slaves ack constantly
        idle_cycles(1);
        run_txn(8'h4A, TIMEOUT - 1, 1'b0, 4'b0000, 1'b0); // ack coincides with timeout
        idle_cycles(1);
        run_txn(8'h60, 0, 1'b0, 4'b0000, 1'b0);       // minimum-length transfer
        run_txn(8'h80, 0, 1'b0, 4'b0000, 1'b0);       // first unmapped address
        run_txn(8'hFF, 0, 1'b0, 4'b0000, 1'b0);       // last unmapped address
        run_txn(8'h20, 1, 1'b0, 4'b0000, 1'b1);       // back-to-back, m_req held
        run_txn(8'h40, 2, 1'b0, 4'b0000, 1'b1);
        idle_cycles(2);

        reset_mid_access();

        // Random transfers.
        for (int n = 0; n < 200; n++) begin
            sel_d = $urandom_range(0, 19);
            d = (sel_d >= 18) ? NO_ACK : sel_d;
            run_txn(8'($urandom), d, 1'b0, 4'b0000, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(30);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        chk("response_count", 32'(responses), 32'(issued));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
